// File: rtl/common_pkg.sv
// -----------------------------------------------------------------------------
// common_pkg
// Shared types for the Quinta front end.
//   instruction_t : one 32-bit instruction word
//   NOP_INSTR     : canonical no-op (addi x0, x0, 0)
//   fetch_entry_t : prefetch buffer entry, instruction word tagged with its PC
// -----------------------------------------------------------------------------
package common_pkg;

  typedef logic [31:0] instruction_t;

  localparam instruction_t NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]  pc;
    instruction_t instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
// Instruction-memory request/response bundle.
//   imem_req_valid/ready/addr : word fetch request handshake
//   imem_rsp_valid/data       : in-order response words, no back-pressure
// Modports: master = fetch stage, slave = instruction memory.
// -----------------------------------------------------------------------------
interface fetch_stage_if;
  import common_pkg::*;

  logic         imem_req_valid;
  logic         imem_req_ready;
  logic [31:0]  imem_req_addr;
  logic         imem_rsp_valid;
  instruction_t imem_rsp_data;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data
  );

endinterface

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous prefetch FIFO of fetch_entry_t.
//   clk, rst   : clock, asynchronous active-high reset
//   push/data  : write an entry (caller guarantees not full)
//   pop/head   : head entry is valid while !empty; pop advances it
//   clear      : empties the FIFO, dominates push/pop
//   count/full/empty : occupancy status
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module fetch_fifo
  import common_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  input  logic                     clear,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t mem_q [DEPTH];
  fetch_entry_t mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clear) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = push_data;
        wr_d        = wr_q + AW'(1);
      end else begin
        wr_d = wr_q;
      end
      if (pop) begin
        rd_d = rd_q + AW'(1);
      end else begin
        rd_d = rd_q;
      end
      cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign head  = mem_q[rd_q];
  assign count = cnt_q;
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/fetch_fifo_chk.sv
// -----------------------------------------------------------------------------
// fetch_fifo_chk
// Property checker for the prefetch FIFO.
//   clk, rst : clock and reset of the checked FIFO
//   push     : FIFO write strobe
//   full     : FIFO full flag
// -----------------------------------------------------------------------------
module fetch_fifo_chk (
  input logic clk,
  input logic rst,
  input logic push,
  input logic full
);

  // The fetch credit scheme must never let a response land in a full buffer.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Quinta instruction fetch: PC generation, imem requests, prefetch buffering
// and the IF/ID pipeline register.
//   clk, rst          : clock, asynchronous active-high reset
//   imem              : instruction memory request/response (master side)
//   stall             : hold IF/ID
//   redirect_valid/pc : take a new PC, low two bits ignored
//   if_id_*           : IF/ID register contents for decode
// A request is only issued when a buffer slot is guaranteed for its response
// (outstanding + buffered < FIFO_DEPTH), so the memory needs no back-pressure.
// -----------------------------------------------------------------------------
module fetch_stage
  import common_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  fetch_stage_if.master        imem,
  input  logic                 stall,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  output logic                 if_id_valid,
  output instruction_t         if_id_instruction,
  output logic [31:0]          if_id_pc,
  output logic [31:0]          if_id_pc_plus4
);

  localparam int              CW     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]     CREDIT = (CW+1)'(FIFO_DEPTH);

  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_q, drop_d;
  logic         valid_q, valid_d;
  instruction_t instr_q, instr_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pc4_q, pc4_d;

  logic         req_valid, accept, rsp, discard, push, pop;
  logic [31:0]  target;
  fetch_entry_t push_entry, head;
  logic [CW-1:0] fifo_count;
  logic         fifo_full, fifo_empty;

  // Handshake decode and fetch/response bookkeeping.
  always_comb begin
    target    = redirect_pc & 32'hFFFF_FFFC;
    req_valid = !rst && !redirect_valid &&
                (({1'b0, outstanding_q} + {1'b0, fifo_count}) < CREDIT);
    accept    = req_valid && imem.imem_req_ready;
    rsp       = imem.imem_rsp_valid;
    discard   = rsp && (drop_q != '0);
    // A response arriving in the redirect cycle is stale by definition.
    push      = rsp && !discard && !redirect_valid;
    pop       = !redirect_valid && !stall && !fifo_empty;
    push_entry = '{pc: rsp_pc_q, instr: imem.imem_rsp_data};

    outstanding_d = outstanding_q + CW'(accept) - CW'(rsp);

    if (redirect_valid) begin
      fetch_pc_d = target;
      rsp_pc_d   = target;
      // Everything still in flight belongs to the old path.
      drop_d     = outstanding_q - CW'(rsp);
    end else begin
      fetch_pc_d = accept ? (fetch_pc_q + 32'd4) : fetch_pc_q;
      rsp_pc_d   = push ? (rsp_pc_q + 32'd4) : rsp_pc_q;
      drop_d     = drop_q - CW'(discard);
    end
  end

  // IF/ID register next state: redirect flushes, stall holds.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    if (redirect_valid) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      if (!fifo_empty) begin
        valid_d = 1'b1;
        instr_d = head.instr;
        pc_d    = head.pc;
        pc4_d   = head.pc + 32'd4;
      end else begin
        valid_d = 1'b0;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Fetch-stage state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      valid_q       <= 1'b0;
      instr_q       <= '0;
      pc_q          <= 32'h0000_0000;
      pc4_q         <= 32'h0000_0000;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      valid_q       <= valid_d;
      instr_q       <= instr_d;
      pc_q          <= pc_d;
      pc4_q         <= pc4_d;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .clear     (redirect_valid),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  fetch_fifo_chk u_fifo_chk (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .full (fifo_full)
  );

  assign imem.imem_req_valid = req_valid;
  assign imem.imem_req_addr  = fetch_pc_q;
  assign if_id_valid         = valid_q;
  assign if_id_instruction   = instr_q;
  assign if_id_pc            = pc_q;
  assign if_id_pc_plus4      = pc4_q;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Directed bench for fetch_stage (RESET_PC=0, FIFO_DEPTH=2). The memory model
// answers one cycle after acceptance with the request address as data, so
// every instruction word equals its own PC.
// -----------------------------------------------------------------------------
module tb_fetch_stage;
  import common_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         stall = 1'b0;
  logic         redirect_valid = 1'b0;
  logic [31:0]  redirect_pc = 32'h0;
  logic         if_id_valid;
  instruction_t if_id_instruction;
  logic [31:0]  if_id_pc;
  logic [31:0]  if_id_pc_plus4;

  logic         mem_hold = 1'b0;
  logic [31:0]  mq[$];

  int           err_cnt = 0;
  int           chk_cnt = 0;
  logic [31:0]  exp_pc  = 32'h0;
  logic [31:0]  exp_req = 32'h0;

  fetch_stage_if imem ();

  fetch_stage #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .imem              (imem),
    .stall             (stall),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .if_id_valid       (if_id_valid),
    .if_id_instruction (if_id_instruction),
    .if_id_pc          (if_id_pc),
    .if_id_pc_plus4    (if_id_pc_plus4)
  );

  always #5 clk = ~clk;

  // In-order instruction memory: one cycle latency, data = address.
  initial begin
    logic        acc;
    logic [31:0] a;
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_data  = 32'h0;
    forever begin
      @(posedge clk);
      acc = imem.imem_req_valid && imem.imem_req_ready && !rst;
      a   = imem.imem_req_addr;
      if (imem.imem_rsp_valid && mq.size() > 0) void'(mq.pop_front());
      if (acc) mq.push_back(a);
      #1;
      if (rst) mq.delete();
      imem.imem_rsp_valid = !rst && !mem_hold && (mq.size() > 0);
      imem.imem_rsp_data  = (mq.size() > 0) ? mq[0] : 32'h0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One clock: check accepted request address, then any newly loaded IF/ID entry.
  task automatic tick();
    logic adv;
    @(posedge clk);
    adv = !stall && !redirect_valid && !rst;
    if (!rst && imem.imem_req_valid && imem.imem_req_ready) begin
      check_eq("req_addr", imem.imem_req_addr, exp_req);
      exp_req += 32'd4;
    end
    @(negedge clk);
    if (adv && if_id_valid) begin
      check_eq("if_pc", if_id_pc, exp_pc);
      check_eq("if_instr", if_id_instruction, exp_pc);
      check_eq("if_pc4", if_id_pc_plus4, exp_pc + 32'd4);
      exp_pc += 32'd4;
    end
  endtask

  task automatic wait_valid(input int max_cycles);
    for (int i = 0; i < max_cycles && !if_id_valid; i++) tick();
    check_eq("wait_valid", {31'b0, if_id_valid}, 32'd1);
  endtask

  initial begin
    logic [3:0] rdy_pat;
    rdy_pat = 4'b1001;
    imem.imem_req_ready = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    check_eq("rst_valid", {31'b0, if_id_valid}, 32'd0);
    check_eq("rst_instr", if_id_instruction, 32'h0);
    check_eq("rst_pc", if_id_pc, 32'h0);
    check_eq("rst_pc4", if_id_pc_plus4, 32'h0);
    check_eq("rst_reqv", {31'b0, imem.imem_req_valid}, 32'd0);

    // Streaming from RESET_PC, two-cycle latency to IF/ID.
    rst = 1'b0;
    #1;
    check_eq("first_reqv", {31'b0, imem.imem_req_valid}, 32'd1);
    check_eq("first_addr", imem.imem_req_addr, 32'h0);
    tick();
    check_eq("lat1_valid", {31'b0, if_id_valid}, 32'd0);
    tick();
    check_eq("lat2_valid", {31'b0, if_id_valid}, 32'd0);
    tick();
    check_eq("lat3_valid", {31'b0, if_id_valid}, 32'd1);
    repeat (10) tick();

    // Stall: IF/ID holds, credits run out, nothing lost after release.
    wait_valid(8);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_valid", {31'b0, if_id_valid}, 32'd1);
      check_eq("stall_pc", if_id_pc, exp_pc - 32'd4);
    end
    check_eq("stall_reqv", {31'b0, imem.imem_req_valid}, 32'd0);
    stall = 1'b0;
    repeat (6) tick();

    // Redirect while stalled flushes a live IF/ID entry.
    wait_valid(8);
    stall = 1'b1;
    repeat (2) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0302;
    tick();
    check_eq("rstall_ifv", {31'b0, if_id_valid}, 32'd0);
    redirect_valid = 1'b0;
    stall          = 1'b0;
    exp_pc  = 32'h0000_0300;
    exp_req = 32'h0000_0300;
    wait_valid(12);
    check_eq("rstall_first", if_id_pc, 32'h0000_0300);
    repeat (4) tick();

    // Ready toggling 1,0,0,1: PC moves only on accepted cycles.
    for (int i = 3; i >= 0; i--) begin
      imem.imem_req_ready = rdy_pat[i];
      tick();
      check_eq("rdy_addr", imem.imem_req_addr, exp_req);
    end
    imem.imem_req_ready = 1'b1;
    repeat (6) tick();

    // Redirect to 0x103 with two requests in flight.
    mem_hold = 1'b1;
    repeat (6) tick();
    check_eq("hold_outst", 32'(mq.size()), 32'd2);
    check_eq("hold_reqv", {31'b0, imem.imem_req_valid}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    #1;
    check_eq("redir_reqv", {31'b0, imem.imem_req_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    mem_hold       = 1'b0;
    exp_pc  = 32'h0000_0100;
    exp_req = 32'h0000_0100;
    check_eq("redir_ifv", {31'b0, if_id_valid}, 32'd0);
    check_eq("redir_addr", imem.imem_req_addr, 32'h0000_0100);
    wait_valid(12);
    check_eq("redir_first", if_id_pc, 32'h0000_0100);
    repeat (4) tick();

    // Redirect + stall + response arriving in the same cycle (drop becomes 1).
    mem_hold = 1'b1;
    repeat (6) tick();
    check_eq("hold2_outst", 32'(mq.size()), 32'd2);
    mem_hold = 1'b0;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    stall          = 1'b1;
    tick();
    redirect_valid = 1'b0;
    stall          = 1'b0;
    exp_pc  = 32'h0000_0200;
    exp_req = 32'h0000_0200;
    check_eq("rs_ifv", {31'b0, if_id_valid}, 32'd0);
    wait_valid(12);
    check_eq("rs_first", if_id_pc, 32'h0000_0200);
    repeat (4) tick();

    // Asynchronous reset mid-stream.
    wait_valid(8);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_valid", {31'b0, if_id_valid}, 32'd0);
    check_eq("arst_instr", if_id_instruction, 32'h0);
    check_eq("arst_pc", if_id_pc, 32'h0);
    check_eq("arst_pc4", if_id_pc_plus4, 32'h0);
    check_eq("arst_reqv", {31'b0, imem.imem_req_valid}, 32'd0);
    repeat (2) tick();
    rst     = 1'b0;
    exp_pc  = 32'h0;
    exp_req = 32'h0;
    #1;
    check_eq("post_rst_reqv", {31'b0, imem.imem_req_valid}, 32'd1);
    check_eq("post_rst_addr", imem.imem_req_addr, 32'h0);
    wait_valid(8);
    check_eq("post_rst_first", if_id_pc, 32'h0);
    repeat (6) tick();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
